// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter granting one requester per write to a shared register.
// Optional grant-hold (lock) feature enabled by defining REG_ARB_LOCK_EN.
module reg_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   wdata,
`ifdef REG_ARB_LOCK_EN
    input  logic [NREQ-1:0]         lock,
`endif
    output logic [NREQ-1:0]         grant,
    output logic                    busy,
    output logic [WIDTH-1:0]        q
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic [1:0]       state_r;
    logic [NREQ-1:0]  grant_r;
    logic             busy_r;
    logic [WIDTH-1:0] q_r;
    logic [IW-1:0]    ptr_r;
    logic [IW-1:0]    idx_r;

    logic [IW-1:0]    sel_s;
    logic             found_s;
    logic [IW-1:0]    ptr_next_s;
    logic [NREQ-1:0]  sel_onehot_s;
    logic [WIDTH-1:0] wr_data_s;

    assign grant = grant_r;
    assign busy  = busy_r;
    assign q     = q_r;

    // Round-robin search: first asserted request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        sel_s    = ptr_r;
        found_s  = 1'b0;
        cand     = 0;
        cand_idx = {IW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_r) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end else begin
                cand = cand;
            end
            cand_idx = IW'(cand);
            if (!found_s && req[cand_idx]) begin
                found_s = 1'b1;
                sel_s   = cand_idx;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer and one-hot form of the winner.
    always_comb begin
        if (sel_s == IW'(NREQ - 1)) begin
            ptr_next_s = {IW{1'b0}};
        end else begin
            ptr_next_s = sel_s + IW'(1);
        end
        sel_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << sel_s;
    end

    // Write-data mux for the currently granted requester.
    always_comb begin
        wr_data_s = {WIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (idx_r == IW'(i)) begin
                wr_data_s = wdata[i*WIDTH +: WIDTH];
            end else begin
                wr_data_s = wr_data_s;
            end
        end
    end

    // Arbitration FSM, shared register and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            grant_r <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            q_r     <= {WIDTH{1'b0}};
            ptr_r   <= {IW{1'b0}};
            idx_r   <= {IW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        state_r <= GRANT;
                        grant_r <= sel_onehot_s;
                        busy_r  <= 1'b1;
                        idx_r   <= sel_s;
                        ptr_r   <= ptr_next_s;
                    end else begin
                        grant_r <= {NREQ{1'b0}};
                        busy_r  <= 1'b0;
                    end
                end
                GRANT: begin
                    // The write happens unconditionally, even if req was dropped.
                    q_r <= wr_data_s;
`ifdef REG_ARB_LOCK_EN
                    if (lock[idx_r]) begin
                        state_r <= LOCKED;
                    end else begin
                        state_r <= IDLE;
                        grant_r <= {NREQ{1'b0}};
                        busy_r  <= 1'b0;
                    end
`else
                    state_r <= IDLE;
                    grant_r <= {NREQ{1'b0}};
                    busy_r  <= 1'b0;
`endif
                end
`ifdef REG_ARB_LOCK_EN
                LOCKED: begin
                    if (req[idx_r]) begin
                        q_r <= wr_data_s;
                    end else begin
                        q_r <= q_r;
                    end
                    if (!lock[idx_r]) begin
                        state_r <= IDLE;
                        grant_r <= {NREQ{1'b0}};
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= LOCKED;
                    end
                end
`endif
                default: begin
                    state_r <= IDLE;
                    grant_r <= {NREQ{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
